// File: rtl/alu_op_sequencer.sv
// Control-step generator for one register-register ALU instruction: fetches the
// instruction, decodes it, then steps the datapath enables through operand
// load, ALU evaluate and writeback (Ra, or LO then HI for multiply/divide).
module alu_op_sequencer #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned REG_SEL_W    = 4,
    parameter int unsigned ALU_SEL_W    = 5,
    parameter logic [ALU_SEL_W-1:0] OP_MUL = 5'b01110,
    parameter logic [ALU_SEL_W-1:0] OP_DIV = 5'b01111,
    parameter logic [ALU_SEL_W-1:0] OP_NEG = 5'b10000,
    parameter logic [ALU_SEL_W-1:0] OP_NOT = 5'b10001,
    parameter logic [ALU_SEL_W-1:0] OP_MAX = 5'b10001,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [31:0]          ir,
    output logic [NUM_REGS-1:0]  reg_in,
    output logic [NUM_REGS-1:0]  reg_out,
    output logic                 pc_out,
    output logic                 mar_in,
    output logic                 inc_pc,
    output logic                 pc_in,
    output logic                 mdr_read,
    output logic                 mdr_in,
    output logic                 mdr_out,
    output logic                 ir_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic                 zlo_out,
    output logic                 zhi_out,
    output logic                 lo_in,
    output logic                 hi_in,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [3:0]           state
);

    localparam int unsigned CntW    = $clog2(MEM_WAIT_MAX + 1);
    localparam int unsigned OpLo    = 32 - ALU_SEL_W;
    localparam int unsigned RaLo    = OpLo - REG_SEL_W;
    localparam int unsigned RbLo    = RaLo - REG_SEL_W;
    localparam int unsigned RcLo    = RbLo - REG_SEL_W;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StT0    = 4'd1,
        StT1    = 4'd2,
        StT2    = 4'd3,
        StT3    = 4'd4,
        StT4    = 4'd5,
        StT5    = 4'd6,
        StT6    = 4'd7,
        StAbort = 4'd8
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [ALU_SEL_W-1:0] opcode;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    logic                 is_muldiv, is_unary, decode_ok;
    logic                 ra_bad, rb_bad, rc_bad;
    logic [NUM_REGS-1:0]  ra_oh, rb_oh, rc_oh;
    logic                 unused_ir;

    assign opcode = ir[31 -: ALU_SEL_W];
    assign ra     = ir[RaLo +: REG_SEL_W];
    assign rb     = ir[RbLo +: REG_SEL_W];
    assign rc     = ir[RcLo +: REG_SEL_W];
    assign unused_ir = ^ir[RcLo-1:0];

    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);

    // Only register fields the opcode actually uses are range-checked.
    assign ra_bad    = !is_muldiv && (32'(ra) >= NUM_REGS);
    assign rb_bad    = 32'(rb) >= NUM_REGS;
    assign rc_bad    = !is_unary && (32'(rc) >= NUM_REGS);
    assign decode_ok = (opcode <= OP_MAX) && !ra_bad && !rb_bad && !rc_bad;

    // An out-of-range index shifts the bit off the end, leaving the bus all-zero.
    assign ra_oh = NUM_REGS'(1) << ra;
    assign rb_oh = NUM_REGS'(1) << rb;
    assign rc_oh = NUM_REGS'(1) << rc;

    assign state = state_q;
    assign busy  = (state_q != StIdle);

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the wait counter only runs while parked in T1.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            StIdle:  if (start) state_d = StT0;
            StT0:    state_d = StT1;
            StT1: begin
                if (mem_ready) begin
                    state_d = StT2;
                end else if (cnt_q == CntW'(MEM_WAIT_MAX - 1)) begin
                    state_d = StAbort;
                end
                cnt_d = (state_d == StT1) ? cnt_q + CntW'(1) : '0;
            end
            StT2:    state_d = StT3;
            StT3:    state_d = decode_ok ? StT4 : StAbort;
            StT4:    state_d = StT5;
            StT5:    state_d = is_muldiv ? StT6 : StIdle;
            StT6:    state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the state register and the IR fields.
    always_comb begin
        reg_in   = '0;
        reg_out  = '0;
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        pc_in    = 1'b0;
        mdr_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        zhi_out  = 1'b0;
        lo_in    = 1'b0;
        hi_in    = 1'b0;
        alu_sel  = '0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            StT0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            StT1: begin
                zlo_out  = 1'b1;
                pc_in    = 1'b1;
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
            end
            StT2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            StT3: begin
                // Unary ops and failed decodes spend this slot idle.
                if (decode_ok && !is_unary) begin
                    reg_out = rb_oh;
                    y_in    = 1'b1;
                end
            end
            StT4: begin
                reg_out = is_unary ? rb_oh : rc_oh;
                z_in    = 1'b1;
                alu_sel = opcode;
            end
            StT5: begin
                zlo_out = 1'b1;
                if (is_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    reg_in = ra_oh;
                    done   = 1'b1;
                end
            end
            StT6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
            StAbort: err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: each scenario queues the expected per-cycle control word for
// every busy cycle; a negedge monitor pops and compares as the DUT steps.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        clr, start, mem_ready;
    logic [31:0] ir;
    logic [15:0] reg_in, reg_out;
    logic        pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
    logic [4:0]  alu_sel;
    logic        busy, done, err;
    logic [3:0]  state;

    alu_op_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mem_ready (mem_ready),
        .ir        (ir),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .inc_pc    (inc_pc),
        .pc_in     (pc_in),
        .mdr_read  (mdr_read),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlo_out   (zlo_out),
        .zhi_out   (zhi_out),
        .lo_in     (lo_in),
        .hi_in     (hi_in),
        .alu_sel   (alu_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4;
    localparam logic [3:0] S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_AB = 4'd8;

    localparam logic [13:0] C_PC_OUT   = 14'h2000, C_MAR_IN  = 14'h1000;
    localparam logic [13:0] C_INC_PC   = 14'h0800, C_PC_IN   = 14'h0400;
    localparam logic [13:0] C_MDR_READ = 14'h0200, C_MDR_IN  = 14'h0100;
    localparam logic [13:0] C_MDR_OUT  = 14'h0080, C_IR_IN   = 14'h0040;
    localparam logic [13:0] C_Y_IN     = 14'h0020, C_Z_IN    = 14'h0010;
    localparam logic [13:0] C_ZLO_OUT  = 14'h0008, C_ZHI_OUT = 14'h0004;
    localparam logic [13:0] C_LO_IN    = 14'h0002, C_HI_IN   = 14'h0001;

    // {state, reg_in, reg_out, 14 control bits, alu_sel, busy, done, err}
    typedef logic [57:0] vec_t;

    vec_t  exp_q[$];
    vec_t  act, exp_v;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    string cur = "reset";

    assign act = {state, reg_in, reg_out, pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in,
                  mdr_out, ir_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, alu_sel,
                  busy, done, err};

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'h0};
    endfunction

    task automatic push(input logic [3:0] st, input logic [15:0] rin, input logic [15:0] rout,
                        input logic [13:0] ctl, input logic [4:0] alu, input logic dn,
                        input logic er);
        exp_q.push_back({st, rin, rout, ctl, alu, 1'b1, dn, er});
    endtask

    task automatic push_fetch(input int waits);
        push(S_T0, 16'h0, 16'h0, C_PC_OUT | C_MAR_IN | C_INC_PC | C_Z_IN, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i <= waits; i++)
            push(S_T1, 16'h0, 16'h0, C_ZLO_OUT | C_PC_IN | C_MDR_READ | C_MDR_IN, 5'h0, 1'b0,
                 1'b0);
        push(S_T2, 16'h0, 16'h0, C_MDR_OUT | C_IR_IN, 5'h0, 1'b0, 1'b0);
    endtask

    // Busy cycles consume the queue; idle cycles must show every output low.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s unexpected_step: got %h, required idle", cur, act);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act !== exp_v) begin
                        n_bad++;
                        $display("FAIL %s step: got %h, required %h", cur, act, exp_v);
                    end
                end
            end else if (act !== 58'h0) begin
                n_bad++;
                $display("FAIL %s idle_outputs: got %h, required 0", cur, act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL %s idle_timeout: busy=%b, required 0", cur, busy);
        end
    endtask

    task automatic check_drained();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s drained: %0d steps left, required 0", cur, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called just after an edge; mem_ready is raised in the last of waits+1 T1 cycles.
    task automatic run_instr(input logic [31:0] word, input int waits, input bit timeout,
                             input bit hold);
        ir        = word;
        start     = 1'b1;
        mem_ready = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        tick();
        if (!timeout) begin
            for (int i = 0; i < waits; i++) tick();
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
        wait_idle();
        start = 1'b0;
        check_drained();
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        ir        = 32'h0;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
        repeat (2) tick();

        cur = "and";
        push_fetch(0);
        push(S_T3, 16'h0, 16'h0004, C_Y_IN, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h0008, C_Z_IN, 5'b00101, 1'b0, 1'b0);
        push(S_T5, 16'h0002, 16'h0, C_ZLO_OUT, 5'h00, 1'b1, 1'b0);
        run_instr(32'h28918000, 0, 1'b0, 1'b0);

        cur = "mem_wait";
        push_fetch(3);
        push(S_T3, 16'h0, 16'h0004, C_Y_IN, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h0008, C_Z_IN, 5'b00101, 1'b0, 1'b0);
        push(S_T5, 16'h0002, 16'h0, C_ZLO_OUT, 5'h00, 1'b1, 1'b0);
        run_instr(32'h28918000, 3, 1'b0, 1'b0);

        cur = "timeout";
        push(S_T0, 16'h0, 16'h0, C_PC_OUT | C_MAR_IN | C_INC_PC | C_Z_IN, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            push(S_T1, 16'h0, 16'h0, C_ZLO_OUT | C_PC_IN | C_MDR_READ | C_MDR_IN, 5'h0, 1'b0,
                 1'b0);
        push(S_AB, 16'h0, 16'h0, 14'h0, 5'h0, 1'b0, 1'b1);
        run_instr(32'h28918000, 0, 1'b1, 1'b0);

        cur = "mul";
        push_fetch(0);
        push(S_T3, 16'h0, 16'h0010, C_Y_IN, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h0020, C_Z_IN, 5'b01110, 1'b0, 1'b0);
        push(S_T5, 16'h0, 16'h0, C_ZLO_OUT | C_LO_IN, 5'h00, 1'b0, 1'b0);
        push(S_T6, 16'h0, 16'h0, C_ZHI_OUT | C_HI_IN, 5'h00, 1'b1, 1'b0);
        run_instr(enc(5'b01110, 4'd0, 4'd4, 4'd5), 0, 1'b0, 1'b0);

        cur = "not";
        push_fetch(0);
        push(S_T3, 16'h0, 16'h0, 14'h0, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h0080, C_Z_IN, 5'b10001, 1'b0, 1'b0);
        push(S_T5, 16'h0040, 16'h0, C_ZLO_OUT, 5'h00, 1'b1, 1'b0);
        run_instr(enc(5'b10001, 4'd6, 4'd7, 4'd3), 0, 1'b0, 1'b0);

        cur = "illegal";
        push_fetch(0);
        push(S_T3, 16'h0, 16'h0, 14'h0, 5'h00, 1'b0, 1'b0);
        push(S_AB, 16'h0, 16'h0, 14'h0, 5'h00, 1'b0, 1'b1);
        run_instr(enc(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1'b0);

        cur = "sub_r0";
        push_fetch(1);
        push(S_T3, 16'h0, 16'h8000, C_Y_IN, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h4000, C_Z_IN, 5'b00100, 1'b0, 1'b0);
        push(S_T5, 16'h0001, 16'h0, C_ZLO_OUT, 5'h00, 1'b1, 1'b0);
        run_instr(enc(5'b00100, 4'd0, 4'd15, 4'd14), 1, 1'b0, 1'b0);

        cur = "div_hold_start";
        push_fetch(0);
        push(S_T3, 16'h0, 16'h0002, C_Y_IN, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h0004, C_Z_IN, 5'b01111, 1'b0, 1'b0);
        push(S_T5, 16'h0, 16'h0, C_ZLO_OUT | C_LO_IN, 5'h00, 1'b0, 1'b0);
        push(S_T6, 16'h0, 16'h0, C_ZHI_OUT | C_HI_IN, 5'h00, 1'b1, 1'b0);
        run_instr(enc(5'b01111, 4'd9, 4'd1, 4'd2), 0, 1'b0, 1'b1);

        cur = "clr_in_t4";
        push_fetch(0);
        push(S_T3, 16'h0, 16'h0004, C_Y_IN, 5'h00, 1'b0, 1'b0);
        push(S_T4, 16'h0, 16'h0008, C_Z_IN, 5'b00101, 1'b0, 1'b0);
        ir    = 32'h28918000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || state !== 4'd0) begin
            n_bad++;
            $display("FAIL %s after_clr: busy=%b state=%0d, required busy=0 state=0", cur, busy,
                     state);
        end
        check_drained();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
